// File: rtl/sd_pattern_gen_if.sv
// sd_pattern_gen_if: srdy/drdy producer bus.
// The generator drives srdy/data; the consumer drives drdy.
interface sd_pattern_gen_if #(
    parameter int width = 8
);
    logic             p_srdy;
    logic             p_drdy;
    logic [width-1:0] p_data;

    modport master (
        output p_srdy,
        output p_data,
        input  p_drdy
    );

    modport slave (
        input  p_srdy,
        input  p_data,
        output p_drdy
    );
endinterface

// File: rtl/sd_pattern_gen.sv
// sd_pattern_gen: srdy/drdy traffic generator with gap pattern,
// inc/LFSR/constant data, bounded transfer count and done flag.
module sd_pattern_gen #(
    parameter int               width       = 8,
    parameter int               pat_dep     = 8,
    parameter int               cnt_w       = 16,
    parameter int               startup_dly = 4,
    parameter logic [width-1:0] lfsr_taps   = width'(8'hB8)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_start,
    input  logic [1:0]          cfg_mode,
    input  logic [cnt_w-1:0]    cfg_count,
    input  logic [width-1:0]    cfg_seed,
    input  logic [pat_dep-1:0]  cfg_srdy_pat,
    sd_pattern_gen_if.master    prod,
    output logic                busy,
    output logic                done,
    output logic [cnt_w-1:0]    xfer_cnt
);

    localparam int spp_w = (pat_dep > 1) ? $clog2(pat_dep) : 1;
    localparam int dly_w = (startup_dly > 1) ? $clog2(startup_dly) : 1;
    localparam logic [spp_w-1:0] spp_last = spp_w'(pat_dep - 1);
    localparam logic [dly_w-1:0] dly_load =
        dly_w'((startup_dly > 0) ? startup_dly - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        STARTUP,
        RUN,
        DONE
    } state_t;

    state_t             state, state_n;
    logic               srdy_q, srdy_n;
    logic [width-1:0]   data_q, data_n;
    logic [spp_w-1:0]   spp, spp_n;
    logic [cnt_w-1:0]   cnt_n;
    logic [dly_w-1:0]   dly_cnt, dly_n;
    logic [1:0]         mode_q, mode_n;
    logic [cnt_w-1:0]   count_q, count_n;
    logic [pat_dep-1:0] pat_q, pat_n;

    logic               xfer;
    logic               opp;
    logic               last;
    logic               is_lfsr;
    logic               is_const;
    logic [width-1:0]   lfsr_nxt;
    logic [width-1:0]   data_adv;
    logic [width-1:0]   seed_n;
    logic [spp_w-1:0]   spp_inc;
    logic [cnt_w-1:0]   cnt_inc;

    assign prod.p_srdy = srdy_q;
    assign prod.p_data = data_q;
    assign busy        = (state == STARTUP) || (state == RUN);
    assign done        = (state == DONE);

    // Handshake terms and the data/pointer/counter successors.
    always_comb begin
        xfer     = srdy_q & prod.p_drdy;
        opp      = !srdy_q | xfer;
        is_lfsr  = (mode_q == 2'd1);
        is_const = (mode_q == 2'd2);
        lfsr_nxt = data_q[0] ? ((data_q >> 1) ^ lfsr_taps)
                             : (data_q >> 1);
        unique case (1'b1)
            is_lfsr:  data_adv = lfsr_nxt;
            is_const: data_adv = data_q;
            default:  data_adv = data_q + 1'b1;
        endcase
        seed_n  = ((cfg_mode == 2'd1) && (cfg_seed == '0))
                  ? width'(1) : cfg_seed;
        spp_inc = (spp == spp_last) ? '0 : spp + 1'b1;
        cnt_inc = xfer_cnt + 1'b1;
        last    = xfer && (count_q != '0) && (cnt_inc == count_q);
    end

    // Next-state and next-register values for the control FSM.
    always_comb begin
        state_n = state;
        srdy_n  = srdy_q;
        data_n  = data_q;
        spp_n   = spp;
        cnt_n   = xfer_cnt;
        dly_n   = dly_cnt;
        mode_n  = mode_q;
        count_n = count_q;
        pat_n   = pat_q;
        case (state)
            IDLE, DONE: begin
                if (cfg_start) begin
                    mode_n  = cfg_mode;
                    count_n = cfg_count;
                    pat_n   = cfg_srdy_pat;
                    data_n  = seed_n;
                    cnt_n   = '0;
                    spp_n   = '0;
                    srdy_n  = 1'b0;
                    dly_n   = dly_load;
                    state_n = (startup_dly == 0) ? RUN : STARTUP;
                end
            end
            STARTUP: begin
                // Last idle cycle already takes the first slot so
                // srdy can rise right after edge start+startup_dly.
                if (dly_cnt == '0) begin
                    state_n = RUN;
                    srdy_n  = pat_q[spp];
                    spp_n   = spp_inc;
                end else begin
                    dly_n = dly_cnt - 1'b1;
                end
            end
            RUN: begin
                if (xfer) begin
                    cnt_n  = cnt_inc;
                    data_n = data_adv;
                end
                if (last) begin
                    srdy_n  = 1'b0;
                    state_n = DONE;
                end else if (opp) begin
                    srdy_n = pat_q[spp];
                    spp_n  = spp_inc;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            srdy_q   <= 1'b0;
            data_q   <= '0;
            spp      <= '0;
            xfer_cnt <= '0;
            dly_cnt  <= '0;
            mode_q   <= '0;
            count_q  <= '0;
            pat_q    <= '0;
        end else begin
            state    <= state_n;
            srdy_q   <= srdy_n;
            data_q   <= data_n;
            spp      <= spp_n;
            xfer_cnt <= cnt_n;
            dly_cnt  <= dly_n;
            mode_q   <= mode_n;
            count_q  <= count_n;
            pat_q    <= pat_n;
        end
    end

endmodule

// File: tb/tb_sd_pattern_gen.sv
// tb_sd_pattern_gen: scenario tasks checked against a
// transfer-index reference model of the generator.
module tb_sd_pattern_gen;

    localparam int W  = 8;
    localparam int CW = 16;
    localparam int P  = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, start0;
    logic [1:0]    mode;
    logic [CW-1:0] count;
    logic [W-1:0]  seed;
    logic [P-1:0]  pat;
    logic          busy, done, busy0, done0;
    logic [CW-1:0] xcnt, xcnt0;

    int n_checks = 0;
    int n_errors = 0;

    sd_pattern_gen_if #(.width(W)) p ();
    sd_pattern_gen_if #(.width(W)) p0 ();

    sd_pattern_gen #(
        .width(W), .pat_dep(P), .cnt_w(CW),
        .startup_dly(D), .lfsr_taps(8'hB8)
    ) u_dut (
        .clk(clk), .reset(reset), .cfg_start(start),
        .cfg_mode(mode), .cfg_count(count), .cfg_seed(seed),
        .cfg_srdy_pat(pat), .prod(p), .busy(busy),
        .done(done), .xfer_cnt(xcnt)
    );

    sd_pattern_gen #(
        .width(W), .pat_dep(P), .cnt_w(CW),
        .startup_dly(0), .lfsr_taps(8'hB8)
    ) u_dut0 (
        .clk(clk), .reset(reset), .cfg_start(start0),
        .cfg_mode(mode), .cfg_count(count), .cfg_seed(seed),
        .cfg_srdy_pat(pat), .prod(p0), .busy(busy0),
        .done(done0), .xfer_cnt(xcnt0)
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 startup, 2 run, 3 done.
    int            m_state;
    logic          m_srdy;
    logic [CW-1:0] m_k;
    int            m_spp;
    int            m_rem;
    logic          m_started;
    logic [1:0]    l_mode;
    logic [CW-1:0] l_count;
    logic [P-1:0]  l_pat;
    logic [W-1:0]  l_seed;

    function automatic logic [W-1:0] lfsr_step(logic [W-1:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    // Word presented after k transfers since start.
    function automatic logic [W-1:0] word_at(logic [CW-1:0] k);
        logic [W-1:0] v;
        v = l_seed;
        case (l_mode)
            2'd1: for (int i = 0; i < int'(k) % 255; i++) v = lfsr_step(v);
            2'd2: v = l_seed;
            default: v = l_seed + W'(k);
        endcase
        return v;
    endfunction

    function automatic logic [W+CW+2:0] exp_vec();
        logic [W-1:0] d;
        d = m_started ? word_at(m_k) : '0;
        return {m_srdy, d, m_k, (m_state == 1 || m_state == 2),
                (m_state == 3)};
    endfunction

    function automatic logic [W+CW+2:0] obs_vec();
        return {p.p_srdy, p.p_data, xcnt, busy, done};
    endfunction

    task automatic model_reset();
        m_state = 0; m_srdy = 0; m_k = '0; m_spp = 0;
        m_rem = 0; m_started = 0;
    endtask

    // One clock: advance the model on the edge, return at negedge.
    task automatic tick();
        logic s_start, s_drdy, x;
        @(posedge clk);
        s_start = start;
        s_drdy  = p.p_drdy;
        case (m_state)
            0, 3: if (s_start) begin
                l_mode    = (mode == 2'd3) ? 2'd0 : mode;
                l_count   = count;
                l_pat     = pat;
                l_seed    = (mode == 2'd1 && seed == 0) ? 8'h01 : seed;
                m_started = 1; m_k = '0; m_spp = 0; m_srdy = 0;
                m_rem     = D;
                m_state   = (D == 0) ? 2 : 1;
            end
            1: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_state = 2;
                    m_srdy  = l_pat[m_spp];
                    m_spp   = (m_spp + 1) % P;
                end
            end
            default: begin
                x = m_srdy && s_drdy;
                if (x) m_k++;
                if (x && l_count != 0 && m_k == l_count) begin
                    m_srdy = 0; m_state = 3;
                end else if (!m_srdy || x) begin
                    m_srdy = l_pat[m_spp];
                    m_spp  = (m_spp + 1) % P;
                end
            end
        endcase
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0; start = 0; start0 = 0;
        model_reset();
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        reset = 0; start = 0; start0 = 0; mode = 0;
        count = 0; seed = 0; pat = 0;
        p.p_drdy = 0; p0.p_drdy = 1;
        model_reset();
        #12;
        n_checks++;
        if (p.p_srdy !== 1'b0) begin
            n_errors++; $display("FAIL rst_srdy: got %b want 0", p.p_srdy);
        end
        n_checks++;
        if (p.p_data !== 8'h00) begin
            n_errors++; $display("FAIL rst_data: got %h want 00", p.p_data);
        end
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_errors++; $display("FAIL rst_flags: got %b%b want 00", busy, done);
        end
        n_checks++;
        if (xcnt !== '0) begin
            n_errors++; $display("FAIL rst_cnt: got %0d want 0", xcnt);
        end
        @(negedge clk);
        reset = 1;
        tick();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_errors++; $display("FAIL rst_idle: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_increment_basic();
        logic [W-1:0] got[$];
        logic [W-1:0] want [4];
        int cyc;
        want = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        mode = 0; seed = 8'hFE; count = 4; pat = 8'hFF; p.p_drdy = 1;
        start = 1; tick(); start = 0;
        cyc = 0;
        while (m_state != 3 && cyc < 50) begin
            if (p.p_srdy && p.p_drdy) got.push_back(p.p_data);
            tick(); cyc++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL inc_cycle: got %h want %h", obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (got.size() != 4) begin
            n_errors++; $display("FAIL inc_nxfer: got %0d want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got[i] !== want[i]) begin
                    n_errors++; $display("FAIL inc_word%0d: got %h want %h", i, got[i], want[i]);
                end
            end
        end
        n_checks++;
        if ({done, xcnt} !== {1'b1, 16'd4}) begin
            n_errors++; $display("FAIL inc_done: got %b/%0d want 1/4", done, xcnt);
        end
        tick();
        n_checks++;
        if (p.p_srdy !== 1'b0 || done !== 1'b1) begin
            n_errors++; $display("FAIL inc_after: got srdy %b done %b want 0 1", p.p_srdy, done);
        end
    endtask

    task automatic test_gap_pattern();
        logic [W-1:0] s;
        int n, cyc;
        do_reset();
        s = W'($urandom);
        mode = 0; seed = s; count = 0; pat = 8'b0101_0101; p.p_drdy = 1;
        start = 1; tick(); start = 0;
        n = 0; cyc = 0;
        while (n < 32 && cyc < 200) begin
            if (p.p_srdy && p.p_drdy) begin
                n_checks++;
                if (p.p_data !== W'(s + W'(n))) begin
                    n_errors++; $display("FAIL gap_word%0d: got %h want %h", n, p.p_data, W'(s + W'(n)));
                end
                n++;
            end
            tick(); cyc++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL gap_cycle: got %h want %h", obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (n != 32) begin
            n_errors++; $display("FAIL gap_count: got %0d want 32", n);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        int cyc;
        do_reset();
        mode = 0; seed = W'($urandom); count = 0;
        pat = P'($urandom) | 8'h01; p.p_drdy = 1;
        start = 1; tick(); start = 0;
        cyc = 0;
        while ((!m_srdy || m_k < 2) && cyc < 40) begin
            tick(); cyc++;
        end
        n_checks++;
        if (obs_vec() !== exp_vec() || p.p_srdy !== 1'b1) begin
            n_errors++; $display("FAIL bp_ready: got %h want %h", obs_vec(), exp_vec());
        end
        p.p_drdy = 0;
        d = p.p_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (p.p_srdy !== 1'b1 || p.p_data !== d) begin
                n_errors++; $display("FAIL bp_hold%0d: got %b/%h want 1/%h", i, p.p_srdy, p.p_data, d);
            end
        end
        p.p_drdy = 1;
        tick();
        n_checks++;
        if (p.p_data !== W'(d + 1)) begin
            n_errors++; $display("FAIL bp_resume: got %h want %h", p.p_data, W'(d + 1));
        end
        for (int i = 0; i < 20; i++) begin
            p.p_drdy = ($urandom % 3) != 0;
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL bp_cycle: got %h want %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_lfsr();
        logic [W-1:0] got[$];
        bit seen [256];
        int cyc, rep;
        do_reset();
        mode = 1; seed = 0; count = 0; pat = 8'hFF; p.p_drdy = 1;
        start = 1; tick(); start = 0;
        cyc = 0;
        while (got.size() < 256 && cyc < 300) begin
            if (p.p_srdy && p.p_drdy) got.push_back(p.p_data);
            tick(); cyc++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL lfsr_cycle: got %h want %h", obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (got.size() != 256) begin
            n_errors++; $display("FAIL lfsr_nxfer: got %0d want 256", got.size());
        end else begin
            n_checks++;
            if ({got[0], got[1], got[2]} !== {8'h01, 8'hB8, 8'h5C}) begin
                n_errors++; $display("FAIL lfsr_first: got %h %h %h want 01 b8 5c", got[0], got[1], got[2]);
            end
            rep = -1;
            for (int i = 0; i < 256; i++) begin
                if (seen[got[i]] && rep < 0) rep = i;
                seen[got[i]] = 1;
            end
            n_checks++;
            if (rep != 255 || got[255] !== got[0]) begin
                n_errors++; $display("FAIL lfsr_period: got %0d want 255", rep);
            end
        end
    endtask

    task automatic test_startup0();
        do_reset();
        mode = 0; seed = 8'h05; count = 3; pat = 8'hFF; p.p_drdy = 1;
        start = 1; start0 = 1; tick(); start = 0; start0 = 0;
        n_checks++;
        if (p0.p_srdy !== 1'b0 || busy0 !== 1'b1) begin
            n_errors++; $display("FAIL su0_e0: got srdy %b busy %b want 0 1", p0.p_srdy, busy0);
        end
        tick();
        n_checks++;
        if (p0.p_srdy !== 1'b1 || p0.p_data !== 8'h05) begin
            n_errors++; $display("FAIL su0_e1: got %b/%h want 1/05", p0.p_srdy, p0.p_data);
        end
        tick(); tick();
        n_checks++;
        if (p.p_srdy !== 1'b0 || busy !== 1'b1) begin
            n_errors++; $display("FAIL su4_e3: got srdy %b busy %b want 0 1", p.p_srdy, busy);
        end
        tick();
        n_checks++;
        if (p.p_srdy !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_errors++; $display("FAIL su4_e4: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_control();
        int cyc, nx;
        do_reset();
        mode = 0; seed = 8'h10; count = 6; pat = 8'hFF; p.p_drdy = 1;
        start = 1; tick(); start = 0;
        repeat (6) tick();
        seed = 8'h99; count = 2; mode = 2;
        start = 1; tick(); start = 0;
        n_checks++;
        if (busy !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_errors++; $display("FAIL ctl_ignore: got %h want %h", obs_vec(), exp_vec());
        end
        cyc = 0;
        while (m_state != 3 && cyc < 40) begin
            tick(); cyc++;
        end
        n_checks++;
        if ({done, xcnt, p.p_data} !== {1'b1, 16'd6, 8'h16}) begin
            n_errors++; $display("FAIL ctl_done6: got %b/%0d/%h want 1/6/16", done, xcnt, p.p_data);
        end
        mode = 0; seed = 8'h40; count = 1;
        start = 1; tick(); start = 0;
        n_checks++;
        if ({xcnt, done, busy} !== {16'd0, 1'b0, 1'b1}) begin
            n_errors++; $display("FAIL ctl_restart: got %0d/%b/%b want 0/0/1", xcnt, done, busy);
        end
        cyc = 0; nx = 0;
        while (m_state != 3 && cyc < 40) begin
            if (p.p_srdy && p.p_drdy) nx++;
            tick(); cyc++;
        end
        repeat (3) begin
            if (p.p_srdy && p.p_drdy) nx++;
            tick();
        end
        n_checks++;
        if (nx != 1 || xcnt !== 16'd1 || p.p_data !== 8'h41) begin
            n_errors++; $display("FAIL ctl_count1: got %0d/%0d/%h want 1/1/41", nx, xcnt, p.p_data);
        end
        seed = 8'h20; count = 2;
        start = 1; tick(); start = 0;
        cyc = 0;
        while (!(m_state == 2 && m_k == 1 && m_srdy) && cyc < 20) begin
            tick(); cyc++;
        end
        start = 1; seed = 8'h77;
        tick(); start = 0;
        n_checks++;
        if ({done, busy} !== 2'b10) begin
            n_errors++; $display("FAIL ctl_race: got done %b busy %b want 1 0", done, busy);
        end
        tick();
        n_checks++;
        if ({done, xcnt} !== {1'b1, 16'd2} || obs_vec() !== exp_vec()) begin
            n_errors++; $display("FAIL ctl_race_hold: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        mode = 0; seed = W'($urandom); count = 0; pat = 8'hFF;
        p.p_drdy = 1;
        start = 1; tick(); start = 0;
        cyc = 0;
        while (!m_srdy && cyc < 20) begin
            tick(); cyc++;
        end
        tick(); tick();
        n_checks++;
        if (p.p_srdy !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_errors++; $display("FAIL ar_pre: got %h want %h", obs_vec(), exp_vec());
        end
        #2 reset = 0;
        #1;
        n_checks++;
        if ({p.p_srdy, p.p_data, busy, done, xcnt} !== '0) begin
            n_errors++; $display("FAIL ar_now: got %b/%h/%b/%b/%0d want all 0", p.p_srdy, p.p_data, busy, done, xcnt);
        end
        model_reset();
        @(negedge clk);
        reset = 1;
        tick();
        n_checks++;
        if (obs_vec() !== exp_vec() || busy !== 1'b0) begin
            n_errors++; $display("FAIL ar_idle: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 8; it++) begin
            for (int c = 0; c < 60; c++) begin
                mode     = 2'($urandom);
                seed     = W'($urandom);
                count    = CW'($urandom_range(0, 12));
                pat      = P'($urandom);
                p.p_drdy = ($urandom % 4) != 0;
                start    = (c == 0) || (($urandom % 10) == 0);
                tick();
                n_checks++;
                if (obs_vec() !== exp_vec()) begin
                    n_errors++; $display("FAIL rnd_cycle%0d_%0d: got %h want %h", it, c, obs_vec(), exp_vec());
                end
            end
        end
        start = 0;
    endtask

    initial begin
        test_reset();
        test_increment_basic();
        test_gap_pattern();
        test_backpressure();
        test_lfsr();
        test_startup0();
        test_control();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
